// File: rtl/seq_mem_arb_pkg.sv
// Shared operation and controller-state encodings for the sequenced memory arbiter.
package seq_mem_arb_pkg;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_BIT = 2'b10,
      OP_NOP = 2'b11
   } mem_op_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/seq_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is accepted.
module seq_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   // high when requester 1 holds the most recent grant; reset value hands the first contest to requester 0
   logic last_one;

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_one ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_one <= 1'b1;
      end else if (advance) begin
         last_one <= grant[1];
      end
   end

endmodule

// File: rtl/seq_mem_arbiter.sv
// Register-array memory shared by two valid/ready requesters; zeroed by an init sweep after reset.
//   state   | meaning
//   ST_INIT | writing zero to mem[init_cnt], requesters held off
//   ST_RUN  | serving one arbitrated access per cycle until next reset
module seq_mem_arbiter
   import seq_mem_arb_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = 8,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int BIT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_done,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [BIT_W-1:0]  req0_bit,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req0_bit_value,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [BIT_W-1:0]  req1_bit,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic              req1_bit_value,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata
);

   ctrl_state_e       state, state_nxt;
   logic [ADDR_W-1:0] init_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              run;
   logic [1:0]        grant;
   logic              accept;
   logic [1:0]        sel_op;
   logic [ADDR_W-1:0] sel_addr;
   logic [BIT_W-1:0]  sel_bit;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_bit_value;
   logic              addr_ok;
   logic              bit_ok;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] wr_word;
   logic              wr_en;

   assign run       = (state == ST_RUN);
   assign init_done = run;

   seq_rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   ({req1_valid, req0_valid}),
      .advance (accept),
      .grant   (grant)
   );

   assign req0_ready = run & req0_valid & grant[0];
   assign req1_ready = run & req1_valid & grant[1];
   assign accept     = req0_ready | req1_ready;

   always_comb begin
      if (req1_ready) begin
         sel_op        = req1_op;
         sel_addr      = req1_addr;
         sel_bit       = req1_bit;
         sel_wdata     = req1_wdata;
         sel_bit_value = req1_bit_value;
      end else begin
         sel_op        = req0_op;
         sel_addr      = req0_addr;
         sel_bit       = req0_bit;
         sel_wdata     = req0_wdata;
         sel_bit_value = req0_bit_value;
      end
   end

   // range guards only exist when the index field can exceed the array/word size
   if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (int'(sel_addr) < DEPTH);
   end

   if (DATA_W == (1 << BIT_W)) begin : g_bit_full
      assign bit_ok = 1'b1;
   end else begin : g_bit_part
      assign bit_ok = (int'(sel_bit) < DATA_W);
   end

   assign rd_word = addr_ok ? mem[sel_addr] : '0;

   always_comb begin
      wr_en   = 1'b0;
      wr_word = rd_word;
      if (accept && addr_ok) begin
         case (mem_op_e'(sel_op))
            OP_WR: begin
               wr_en   = 1'b1;
               wr_word = sel_wdata;
            end
            OP_BIT: begin
               if (bit_ok) begin
                  wr_en            = 1'b1;
                  wr_word[sel_bit] = sel_bit_value;
               end
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) init_cnt <= init_cnt + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         mem[init_cnt] <= '0;
      end else if (wr_en) begin
         mem[sel_addr] <= wr_word;
      end
   end

   // rdata captures the pre-write word and holds it between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= req0_ready;
         rsp1_valid <= req1_ready;
         if (req0_ready) rsp0_rdata <= rd_word;
         if (req1_ready) rsp1_rdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_seq_mem_arbiter.sv
// Bench for seq_mem_arbiter: reference memory model feeds a response scoreboard; a narrow build covers range guards.
module tb_seq_mem_arbiter;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       init_done;
   logic       req0_valid, req0_ready, req0_bit_value, rsp0_valid;
   logic [1:0] req0_op;
   logic [3:0] req0_addr;
   logic [2:0] req0_bit;
   logic [7:0] req0_wdata, rsp0_rdata;
   logic       req1_valid, req1_ready, req1_bit_value, rsp1_valid;
   logic [1:0] req1_op;
   logic [3:0] req1_addr;
   logic [2:0] req1_bit;
   logic [7:0] req1_wdata, rsp1_rdata;

   seq_mem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_addr(req0_addr), .req0_bit(req0_bit), .req0_wdata(req0_wdata),
      .req0_bit_value(req0_bit_value), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_addr(req1_addr), .req1_bit(req1_bit), .req1_wdata(req1_wdata),
      .req1_bit_value(req1_bit_value), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata)
   );

   // narrow build: 12 words of 6 bits, so both address and bit index can be out of range
   logic       b_init_done;
   logic       b_req0_ready, b_rsp0_valid, b_req1_valid, b_req1_ready, b_req1_bit_value, b_rsp1_valid;
   logic [1:0] b_req1_op;
   logic [3:0] b_req1_addr;
   logic [2:0] b_req1_bit;
   logic [5:0] b_req1_wdata, b_rsp0_rdata, b_rsp1_rdata;

   seq_mem_arbiter #(.DEPTH(12), .DATA_W(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .init_done(b_init_done),
      .req0_valid(1'b0), .req0_ready(b_req0_ready), .req0_op(2'b11),
      .req0_addr(4'd0), .req0_bit(3'd0), .req0_wdata(6'd0),
      .req0_bit_value(1'b0), .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
      .req1_addr(b_req1_addr), .req1_bit(b_req1_bit), .req1_wdata(b_req1_wdata),
      .req1_bit_value(b_req1_bit_value), .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   logic [7:0] mmem [DEPTH];
   int         last_g;
   exp_t       q0[$];
   exp_t       q1[$];
   exp_t       popped;
   logic [7:0] last_rd0, last_rd1;
   logic [7:0] old_word;
   logic       run_e, e0, e1;
   int         cyc = 0;
   int         rel = 0;

   task automatic model_reset();
      foreach (mmem[i]) mmem[i] = 8'h00;
      last_g = 1;
      q0.delete();
      q1.delete();
      last_rd0 = 8'h00;
      last_rd1 = 8'h00;
   endtask

   task automatic model_access(input logic [1:0] op, input logic [3:0] a, input logic [2:0] b,
                               input logic [7:0] wd, input logic bv, output logic [7:0] old);
      old = mmem[a];
      if (op == 2'd1) mmem[a] = wd;
      else if (op == 2'd2) mmem[a][b] = bv;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rel <= 0;
      else        rel <= rel + 1;
   end

   // expected grant: the lone valid requester, or the one not granted last
   always @(negedge clk) begin
      if (rst_n) begin
         run_e = (rel >= DEPTH);
         check("init_done", init_done, run_e);
         e0 = run_e && req0_valid && (!req1_valid || last_g == 1);
         e1 = run_e && req1_valid && (!req0_valid || last_g == 0);
         check("ready0", req0_ready, e0);
         check("ready1", req1_ready, e1);
         if (e0) begin
            model_access(req0_op, req0_addr, req0_bit, req0_wdata, req0_bit_value, old_word);
            q0.push_back('{d: old_word, c: cyc});
            last_g = 0;
         end else if (e1) begin
            model_access(req1_op, req1_addr, req1_bit, req1_wdata, req1_bit_value, old_word);
            q1.push_back('{d: old_word, c: cyc});
            last_g = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp0_valid) begin
            if (q0.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rsp0_spurious: got valid with rdata %0h, expected no response (t=%0t)", rsp0_rdata, $time);
            end else begin
               popped = q0.pop_front();
               check("rsp0_latency", cyc, popped.c + 1);
               check("rsp0_rdata", rsp0_rdata, popped.d);
               last_rd0 = popped.d;
            end
         end else begin
            check("rsp0_hold", rsp0_rdata, last_rd0);
            if (q0.size() > 0 && q0[0].c + 1 <= cyc) begin
               n_cmp++; n_bad++;
               $display("FAIL rsp0_missing: got no valid, expected rdata %0h (t=%0t)", q0[0].d, $time);
               popped = q0.pop_front();
            end
         end
         if (rsp1_valid) begin
            if (q1.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rsp1_spurious: got valid with rdata %0h, expected no response (t=%0t)", rsp1_rdata, $time);
            end else begin
               popped = q1.pop_front();
               check("rsp1_latency", cyc, popped.c + 1);
               check("rsp1_rdata", rsp1_rdata, popped.d);
               last_rd1 = popped.d;
            end
         end else begin
            check("rsp1_hold", rsp1_rdata, last_rd1);
            if (q1.size() > 0 && q1[0].c + 1 <= cyc) begin
               n_cmp++; n_bad++;
               $display("FAIL rsp1_missing: got no valid, expected rdata %0h (t=%0t)", q1[0].d, $time);
               popped = q1.pop_front();
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_req(input int n, input logic [1:0] op, input logic [3:0] a, input logic [2:0] b,
                          input logic [7:0] wd, input logic bv);
      if (n == 0) begin
         req0_op = op; req0_addr = a; req0_bit = b; req0_wdata = wd; req0_bit_value = bv; req0_valid = 1'b1;
      end else begin
         req1_op = op; req1_addr = a; req1_bit = b; req1_wdata = wd; req1_bit_value = bv; req1_valid = 1'b1;
      end
   endtask

   task automatic wait_accept(input int n);
      bit got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         got = (n == 0) ? req0_ready : req1_ready;
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got no ready, expected req%0d accepted within 64 cycles", n);
      end
      @(posedge clk); #1;
      if (n == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic issue(input int n, input logic [1:0] op, input logic [3:0] a, input logic [2:0] b,
                        input logic [7:0] wd, input logic bv);
      set_req(n, op, a, b, wd, bv);
      wait_accept(n);
   endtask

   task automatic init_wait();
      for (int i = 1; i <= DEPTH; i++) begin
         @(posedge clk); #1;
         check("init_done_edge", init_done, (i == DEPTH));
      end
   endtask

   task automatic rand_req(input int n);
      if ($urandom_range(0, 3) == 0) begin
         if (n == 0) req0_valid = 1'b0;
         else        req1_valid = 1'b0;
      end else begin
         set_req(n, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 8'($urandom), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic b_op(input logic [1:0] op, input logic [3:0] a, input logic [2:0] b, input logic [5:0] wd,
                       input logic bv, input logic [5:0] exp_rd, input string name);
      bit got = 1'b0;
      b_req1_op = op; b_req1_addr = a; b_req1_bit = b; b_req1_wdata = wd; b_req1_bit_value = bv;
      b_req1_valid = 1'b1;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         got = b_req1_ready;
      end
      @(posedge clk); #1;
      b_req1_valid = 1'b0;
      check({name, "_valid"}, b_rsp1_valid, 1'b1);
      check(name, b_rsp1_rdata, exp_rd);
   endtask

   logic a0, a1;

   initial begin
      req0_valid = 0; req0_op = 0; req0_addr = 0; req0_bit = 0; req0_wdata = 0; req0_bit_value = 0;
      req1_valid = 0; req1_op = 0; req1_addr = 0; req1_bit = 0; req1_wdata = 0; req1_bit_value = 0;
      b_req1_valid = 0; b_req1_op = 0; b_req1_addr = 0; b_req1_bit = 0; b_req1_wdata = 0; b_req1_bit_value = 0;
      model_reset();

      // reset state, then both requesters read addr 5 through the init sweep
      repeat (3) @(posedge clk);
      #1;
      set_req(0, 2'd0, 4'd5, 3'd0, 8'h00, 1'b0);
      set_req(1, 2'd0, 4'd5, 3'd0, 8'h00, 1'b0);
      #1;
      check("rst_init_done", init_done, 1'b0);
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_ready1", req1_ready, 1'b0);
      check("rst_rsp0_valid", rsp0_valid, 1'b0);
      check("rst_rsp1_rdata", rsp1_rdata, 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      init_wait();
      check("first_ready0", req0_ready, 1'b1);
      wait_accept(0);
      wait_accept(1);

      // word write then read, bit write then read
      issue(0, 2'd1, 4'd3, 3'd0, 8'hA5, 1'b0);
      issue(0, 2'd0, 4'd3, 3'd0, 8'h00, 1'b0);
      issue(1, 2'd2, 4'd3, 3'd1, 8'h00, 1'b1);
      issue(1, 2'd0, 4'd3, 3'd0, 8'h00, 1'b0);

      // contested reads alternate, starting with req0 since req1 was granted last
      set_req(0, 2'd0, 4'd0, 3'd0, 8'h00, 1'b0);
      set_req(1, 2'd0, 4'd1, 3'd0, 8'h00, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("contest_g0", req0_ready, (k % 2 == 0));
         check("contest_g1", req1_ready, (k % 2 == 1));
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;

      // randomized traffic, payload held while valid is pending
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         a0 = req0_ready; a1 = req1_ready;
         @(posedge clk); #1;
         if (!req0_valid || a0) rand_req(0);
         if (!req1_valid || a1) rand_req(1);
      end
      @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // reset right after an accepted write drops the response and re-zeroes the array
      issue(0, 2'd1, 4'd7, 3'd0, 8'hFF, 1'b0);
      check("pre_rst_rsp0_valid", rsp0_valid, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
      check("mid_rst_rsp0_rdata", rsp0_rdata, 8'h00);
      check("mid_rst_init_done", init_done, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      init_wait();
      issue(0, 2'd0, 4'd7, 3'd0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // narrow build: out-of-range bit and address accesses leave memory untouched
      b_op(2'd1, 4'd2, 3'd0, 6'h2A, 1'b0, 6'h00, "b_wr");
      b_op(2'd2, 4'd2, 3'd6, 6'h00, 1'b1, 6'h2A, "b_bit6");
      b_op(2'd2, 4'd2, 3'd7, 6'h00, 1'b1, 6'h2A, "b_bit7");
      b_op(2'd0, 4'd2, 3'd0, 6'h00, 1'b0, 6'h2A, "b_rd_after_oob_bit");
      b_op(2'd2, 4'd2, 3'd0, 6'h00, 1'b1, 6'h2A, "b_bit0");
      b_op(2'd0, 4'd2, 3'd0, 6'h00, 1'b0, 6'h2B, "b_rd_after_bit0");
      b_op(2'd1, 4'd13, 3'd0, 6'h15, 1'b0, 6'h00, "b_wr_oob_addr");
      b_op(2'd0, 4'd13, 3'd0, 6'h00, 1'b0, 6'h00, "b_rd_oob_addr");
      b_op(2'd0, 4'd1, 3'd0, 6'h00, 1'b0, 6'h00, "b_rd_addr1");

      repeat (3) @(posedge clk);
      #1;
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
